// File: rtl/oct_key_counter.sv
// Debounced pushbutton driving a 3-bit octal up/down counter with load; press/wrap are one-cycle pulses.
// Latency: a key level held from before edge 1 is accepted, counted and pulsed at edge DEBOUNCE_CYCLES+2.
module oct_key_counter #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic       CLOCK_50,
   input  logic       rst,
   input  logic       key_n,
   input  logic       up_dn,
   input  logic       load,
   input  logic [2:0] load_val,
   output logic [2:0] digit,
   output logic       press,
   output logic       wrap
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          s1;
   logic          s2;
   logic          stable;
   logic [CW-1:0] cnt;
   logic          accept;
   logic          fall;
   logic          at_edge;

   // The level flips on the very edge where the N-th mismatching sample is seen.
   assign accept  = (s2 != stable) && (cnt == CNT_MAX);
   assign fall    = accept && stable;
   assign at_edge = up_dn ? (digit == 3'd7) : (digit == 3'd0);

   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         s1     <= 1'b1;
         s2     <= 1'b1;
         stable <= 1'b1;
         cnt    <= '0;
         digit  <= 3'd0;
         press  <= 1'b0;
         wrap   <= 1'b0;
      end else begin
         s1 <= key_n;
         s2 <= s1;

         if (s2 == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            stable <= s2;
            cnt    <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end

         press <= fall;
         wrap  <= fall && !load && at_edge;

         // Load wins over a coincident press; the press pulse itself is still reported.
         if (load) begin
            digit <= load_val;
         end else if (fall) begin
            digit <= up_dn ? digit + 3'd1 : digit - 3'd1;
         end
      end
   end

endmodule

// File: tb/tb_oct_key_counter.sv
// Bench for oct_key_counter with N = 4: directed sequences, a press table, and random stimulus against a window model.
module tb_oct_key_counter;

   localparam int N = 4;

   logic       clk;
   logic       rst;
   logic       key_n;
   logic       up_dn;
   logic       load;
   logic [2:0] load_val;
   logic [2:0] digit;
   logic       press;
   logic       wrap;

   int errors = 0;
   int checks = 0;

   oct_key_counter #(.DEBOUNCE_CYCLES(N)) dut (
      .CLOCK_50 (clk),
      .rst      (rst),
      .key_n    (key_n),
      .up_dn    (up_dn),
      .load     (load),
      .load_val (load_val),
      .digit    (digit),
      .press    (press),
      .wrap     (wrap)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference: a two-deep delay line for synchronisation, then a level flips
   // once the last N synchronised samples all disagree with it.
   logic       m_q[$];
   logic       m_hist[N];
   logic       m_stable;
   logic [2:0] m_digit;
   logic       m_press;
   logic       m_wrap;

   task automatic model_step();
      logic samp;
      logic all_diff;
      logic fell;
      int   nd;
      if (rst) begin
         m_q.delete();
         m_q.push_back(1'b1);
         m_q.push_back(1'b1);
         for (int i = 0; i < N; i++) m_hist[i] = 1'b1;
         m_stable = 1'b1;
         m_digit  = 3'd0;
         m_press  = 1'b0;
         m_wrap   = 1'b0;
      end else begin
         samp = m_q.pop_front();
         m_q.push_back(key_n);
         for (int i = 0; i < N - 1; i++) m_hist[i] = m_hist[i+1];
         m_hist[N-1] = samp;
         all_diff = 1'b1;
         for (int i = 0; i < N; i++) if (m_hist[i] == m_stable) all_diff = 1'b0;
         fell = all_diff && m_stable;
         if (all_diff) m_stable = ~m_stable;
         m_press = fell;
         m_wrap  = 1'b0;
         if (fell) begin
            nd = int'(m_digit) + (up_dn ? 1 : -1);
            m_wrap = !load && (nd < 0 || nd > 7);
         end
         if (load) m_digit = load_val;
         else if (fell) m_digit = 3'((nd + 8) % 8);
      end
   endtask

   task automatic chk_d(input string name, input logic [2:0] act, input logic [2:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_b(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // One rising edge; inputs are only ever changed 1 time unit after an edge.
   task automatic tick();
      @(posedge clk);
      #1;
      model_step();
      chk_d("model_digit", digit, m_digit);
      chk_b("model_press", press, m_press);
      chk_b("model_wrap", wrap, m_wrap);
   endtask

   typedef struct {
      logic       up;
      logic       ld;
      logic [2:0] lv;
      logic [2:0] exp_digit;
      logic       exp_wrap;
   } press_vec_t;

   press_vec_t tbl[14];
   int         run;

   initial begin
      for (int i = 0; i < 8; i++) tbl[i] = '{1'b1, 1'b0, 3'd0, 3'(i + 1), (i == 7)};
      tbl[8]  = '{1'b0, 1'b0, 3'd0, 3'd7, 1'b1};
      tbl[9]  = '{1'b1, 1'b0, 3'd0, 3'd0, 1'b1};
      tbl[10] = '{1'b1, 1'b0, 3'd0, 3'd1, 1'b0};
      tbl[11] = '{1'b1, 1'b0, 3'd0, 3'd2, 1'b0};
      tbl[12] = '{1'b1, 1'b1, 3'd5, 3'd5, 1'b0};
      tbl[13] = '{1'b0, 1'b0, 3'd0, 3'd4, 1'b0};

      rst = 1'b1; key_n = 1'b1; up_dn = 1'b1; load = 1'b0; load_val = 3'd0;
      tick();
      tick();
      chk_d("reset_digit", digit, 3'd0);
      chk_b("reset_press", press, 1'b0);
      chk_b("reset_wrap", wrap, 1'b0);

      // V1: key held low from before edge 1; accepted at edge N+2
      rst = 1'b0; key_n = 1'b0;
      for (int e = 1; e <= 20; e++) begin
         tick();
         if (e < N + 2) begin
            chk_b("v1_press_early", press, 1'b0);
            chk_d("v1_digit_early", digit, 3'd0);
         end else if (e == N + 2) begin
            chk_b("v1_press_edge", press, 1'b1);
            chk_d("v1_digit_edge", digit, 3'd1);
         end else begin
            chk_b("v1_hold_no_repeat", press, 1'b0);
            chk_d("v1_digit_hold", digit, 3'd1);
         end
      end
      key_n = 1'b1;
      repeat (12) begin
         tick();
         chk_b("v1_release_press", press, 1'b0);
         chk_d("v1_release_digit", digit, 3'd1);
      end

      // V2: 2-cycle bounce never qualifies
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int e = 0; e < 20; e++) begin
         key_n = ((e / 2) % 2 == 0) ? 1'b0 : 1'b1;
         tick();
         chk_b("v2_press", press, 1'b0);
         chk_d("v2_digit", digit, 3'd0);
      end
      key_n = 1'b1;
      repeat (10) begin
         tick();
         chk_b("v2_settle_press", press, 1'b0);
      end

      // V3/V4/V5: clean presses, load applied on the acceptance edge only
      for (int i = 0; i < 14; i++) begin
         up_dn = tbl[i].up;
         key_n = 1'b0;
         repeat (N + 1) begin
            tick();
            chk_b("tbl_press_early", press, 1'b0);
         end
         load = tbl[i].ld;
         load_val = tbl[i].lv;
         tick();
         chk_d("tbl_digit", digit, tbl[i].exp_digit);
         chk_b("tbl_press", press, 1'b1);
         chk_b("tbl_wrap", wrap, tbl[i].exp_wrap);
         load = 1'b0;
         key_n = 1'b1;
         repeat (N + 4) begin
            tick();
            chk_b("tbl_release_press", press, 1'b0);
            chk_d("tbl_release_digit", digit, tbl[i].exp_digit);
         end
      end

      // V6: reset at cnt = 2 with key held (and a load that reset must override)
      up_dn = 1'b1;
      key_n = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         tick();
         chk_b("v6_pre_press", press, 1'b0);
         chk_d("v6_pre_digit", digit, 3'd4);
      end
      rst = 1'b1; load = 1'b1; load_val = 3'd6;
      tick();
      chk_d("v6_reset_digit", digit, 3'd0);
      chk_b("v6_reset_press", press, 1'b0);
      chk_b("v6_reset_wrap", wrap, 1'b0);
      rst = 1'b0; load = 1'b0;
      for (int e = 1; e <= 16; e++) begin
         tick();
         if (e < N + 2) begin
            chk_b("v6_press_early", press, 1'b0);
            chk_d("v6_digit_early", digit, 3'd0);
         end else if (e == N + 2) begin
            chk_b("v6_press_edge", press, 1'b1);
            chk_d("v6_digit_edge", digit, 3'd1);
         end else begin
            chk_b("v6_no_repeat", press, 1'b0);
            chk_d("v6_digit_hold", digit, 3'd1);
         end
      end
      key_n = 1'b1;
      repeat (N + 4) tick();

      // Random key runs around the debounce threshold, direction, loads and resets
      run = 0;
      for (int c = 0; c < 4000; c++) begin
         if (run == 0) begin
            key_n = ~key_n;
            run = $urandom_range(1, 12);
         end
         run--;
         up_dn    = 1'($urandom);
         load     = ($urandom_range(0, 15) == 0);
         load_val = 3'($urandom);
         rst      = ($urandom_range(0, 299) == 0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
